// File: rtl/bit_adj_16b_to_32b_pkg.sv
// Shared types and widths for the 16b->32b bit adjuster and its skid buffer.
package bit_adj_16b_to_32b_pkg;
  localparam int DATA_W_IN  = 16;
  localparam int DATA_W_OUT = 32;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;
endpackage

// File: rtl/bit_adj_16b_to_32b_skid_buf_2e.sv
// Generic 2-entry valid/ready skid buffer; o_ready and o_valid are registered.
module skid_buf_2e
  import bit_adj_16b_to_32b_pkg::*;
#(
  parameter int W = DATA_W_OUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  skid_state_e r_state, w_nxt;
  logic [W-1:0] r_head, r_tail;
  logic         r_rdy, r_vld;
  logic         w_in, w_out;

  assign w_in  = i_valid && r_rdy;
  assign w_out = r_vld && i_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_in) w_nxt = S_ONE;
      S_ONE: begin
        if (w_in && !w_out)      w_nxt = S_FULL;
        else if (!w_in && w_out) w_nxt = S_EMPTY;
      end
      S_FULL:  if (w_out) w_nxt = S_ONE;
      default: w_nxt = S_EMPTY;
    endcase
    if (i_clr) w_nxt = S_EMPTY;
  end

  // r_head is always the presented word; r_tail only holds the skid entry in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rdy   <= (w_nxt != S_FULL);
      r_vld   <= (w_nxt != S_EMPTY);
      if (i_clr) begin
        r_head <= '0;
      end else begin
        case (r_state)
          S_EMPTY: if (w_in) r_head <= i_data;
          S_ONE: begin
            if (w_in && w_out) r_head <= i_data;
            else if (w_in)     r_tail <= i_data;
          end
          S_FULL:  if (w_out) r_head <= r_tail;
          default: ;
        endcase
      end
    end
  end

  assign o_ready = r_rdy;
  assign o_valid = r_vld;
  assign o_data  = r_head;
endmodule

// File: rtl/bit_adj_16b_to_32b.sv
// Expands a 16-bit fixed-point sample into a 32-bit word through a skid buffer.
// Optional frame counter / o_last enabled by defining BIT_ADJ_FRAME_CNT_EN.
module bit_adj_16b_to_32b
  import bit_adj_16b_to_32b_pkg::*;
#(
  parameter int FRAC_SHIFT = 12,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W_IN-1:0]  i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_W_OUT-1:0] o_data,
  output logic                  o_last
);
  logic [DATA_W_OUT-1:0] w_sext, w_map;
  logic                  w_vld;

  assign w_sext = {{(DATA_W_OUT-DATA_W_IN){i_data[DATA_W_IN-1]}}, i_data};
  assign w_map  = w_sext << FRAC_SHIFT;

  skid_buf_2e #(.W(DATA_W_OUT)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (w_map),
    .o_valid (w_vld),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  assign o_valid = w_vld;

`ifdef BIT_ADJ_FRAME_CNT_EN
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter tags the presented word, so it advances only on output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_vld && i_ready) begin
      r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_last = w_vld && (r_cnt == LAST_IDX);
`else
  assign o_last = 1'b0;
`endif
endmodule

// File: tb/tb_bit_adj_16b_to_32b.sv
// Self-checking bench: table vectors, directed corner sequences, random stream vs queue model.
module tb_bit_adj_16b_to_32b;
  localparam int FS = 12;
  localparam int FL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_last;

  always #5 clk = ~clk;

  bit_adj_16b_to_32b #(.FRAC_SHIFT(FS), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO of accepted samples, output frame index, ready-after-reset flag.
  logic [15:0] q[$];
  int          cnt = 0;
  bit          rdy_ok = 0;
  int          lasts_seen = 0;
  int          outs_seen = 0;

  typedef struct {
    logic [15:0] din;
    logic [31:0] dout;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_map(input logic [15:0] d);
    longint v;
    v = longint'($signed(d)) * (longint'(1) << FS);
    return v[31:0];
  endfunction

  // Downstream 32b->16b reducer: round half up at FS, saturate to 16 bits.
  function automatic logic [15:0] reduce(input logic [31:0] w);
    longint s;
    s = longint'($signed(w));
    if (FS > 0) s = s + (longint'(1) << (FS - 1));
    s = s >>> FS;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic exp_last();
`ifdef BIT_ADJ_FRAME_CNT_EN
    return (cnt == FL - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge: drive, check presented state, advance model, step one cycle.
  task automatic tick(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
    bit m_rdy, m_vld, acc, xo;
    i_valid = v; i_data = d; i_ready = rdy; i_clr = clr;
    #1;
    m_rdy = rdy_ok && (q.size() < 2);
    m_vld = (q.size() != 0);
    chk("o_ready", {31'd0, o_ready}, {31'd0, m_rdy});
    chk("o_valid", {31'd0, o_valid}, {31'd0, m_vld});
    if (m_vld) begin
      chk("o_data", o_data, mdl_map(q[0]));
      chk("o_last", {31'd0, o_last}, {31'd0, exp_last()});
      chk("round_trip", {16'd0, reduce(o_data)}, {16'd0, q[0]});
    end
    if (o_valid && rdy) begin
      outs_seen++;
      if (o_last) lasts_seen++;
    end
    acc = v && m_rdy;
    xo  = m_vld && rdy;
    if (clr) begin
      q.delete();
      cnt = 0;
    end else begin
      if (xo) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % FL;
      end
      if (acc) q.push_back(d);
    end
    @(posedge clk);
    if (rst_n) rdy_ok = 1;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    cnt = 0;
    rdy_ok = 0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_hold_data", o_data, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_lasts;
    vt[0] = '{16'h8001, 32'hF8001000};
    vt[1] = '{16'h7FFF, 32'h07FFF000};
    vt[2] = '{16'h0000, 32'h00000000};
    vt[3] = '{16'h0001, 32'h00001000};
    vt[4] = '{16'hFFFF, 32'hFFFFF000};
    vt[5] = '{16'h8000, 32'hF8000000};

    @(negedge clk);
    do_reset(3);
    // First edge after release raises o_ready.
    chk("rel_ready_pre", {31'd0, o_ready}, 32'd0);
    tick(0, 16'h0, 1, 0);
    chk("rel_ready_post", {31'd0, o_ready}, 32'd1);

    // Mapping table with 1-cycle latency from EMPTY.
    for (int i = 0; i < 6; i++) begin
      tick(1, vt[i].din, 1, 0);
      #1;
      chk("map_vec", o_data, vt[i].dout);
      chk("map_valid", {31'd0, o_valid}, 32'd1);
      tick(0, 16'h0, 1, 0);
    end

    // Backpressure: only two accepted, then drained in order.
    for (int i = 0; i < 5; i++) tick(1, 16'h1000 + 16'(i), 0, 0);
    #1;
    chk("bp_ready_low", {31'd0, o_ready}, 32'd0);
    outs_seen = 0;
    for (int i = 0; i < 4; i++) tick(0, 16'h0, 1, 0);
    chk("bp_drained", outs_seen, 32'd2);

    // Clear while FULL with a sample offered: it is dropped.
    tick(1, 16'h1111, 0, 0);
    tick(1, 16'h2222, 0, 0);
    tick(1, 16'h3333, 0, 1);
    #1;
    chk("clr_valid", {31'd0, o_valid}, 32'd0);
    chk("clr_ready", {31'd0, o_ready}, 32'd1);

    // Frame: 130 back-to-back samples.
    lasts_seen = 0;
    outs_seen = 0;
    for (int i = 0; i < 130; i++) tick(1, 16'($urandom), 1, 0);
    tick(0, 16'h0, 1, 0);
    chk("frame_outs", outs_seen, 32'd130);
`ifdef BIT_ADJ_FRAME_CNT_EN
    exp_lasts = 2;
`else
    exp_lasts = 0;
`endif
    chk("frame_lasts", lasts_seen, exp_lasts);

    // Random stream with occasional clear and one mid-frame reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      tick(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 4; i++) tick(0, 16'h0, 1, 0);
    #1;
    chk("final_empty", {31'd0, o_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
